md_unit: RTL and testbench

Multiply/divide unit for the pipelined CPU, sitting beside the ALU in the EX stage. It accepts one operation per start pulse, holds the HI/LO architectural registers, and models the fixed multi-cycle latency of MULT/DIV with a busy countdown. The pipeline hazard logic uses `stall` to freeze decode while a result is pending.

---
 rtl/md_unit_pkg.sv | 65 ++++++
 rtl/md_unit_if.sv | 20 ++
 rtl/md_unit_counter.sv | 39 +++
 rtl/md_unit.sv | 119 +++++++++++
 tb/tb_md_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared types for the multiply/divide unit.
//   mduop_e  - operation select carried on the op field
//   state_e  - controller state
//   hilo_t   - {hi, lo} result pair
//   is_long_op / div32 - helpers used by the unit
package md_unit_pkg;

    localparam int MDUOP_SIZE = 3;

    typedef enum logic [MDUOP_SIZE-1:0] {
        MDUOP_NONE  = 3'd0,
        MDUOP_MULT  = 3'd1,
        MDUOP_MULTU = 3'd2,
        MDUOP_DIV   = 3'd3,
        MDUOP_DIVU  = 3'd4,
        MDUOP_MTHI  = 3'd5,
        MDUOP_MTLO  = 3'd6
    } mduop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Operations that occupy the unit for a latency window.
    function automatic logic is_long_op(input logic [MDUOP_SIZE-1:0] op);
        return (op == MDUOP_MULT) || (op == MDUOP_MULTU) ||
               (op == MDUOP_DIV)  || (op == MDUOP_DIVU);
    endfunction

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. Working on magnitudes keeps
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    // A zero divisor returns zeros; the caller discards the result.
    function automatic hilo_t div32(input logic [31:0] a, input logic [31:0] b,
                                    input logic is_signed);
        hilo_t       res;
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        res.lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res.hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        return res;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the EX stage and md_unit.
//   start, op, rs_val, rt_val - request from the pipeline (master drives)
//   busy, stall, hi, lo       - status and architectural HI/LO (slave drives)
interface md_unit_if;
    import md_unit_pkg::*;

    logic                  start;
    logic [MDUOP_SIZE-1:0] op;
    logic [31:0]           rs_val;
    logic [31:0]           rt_val;
    logic                  busy;
    logic                  stall;
    logic [31:0]           hi;
    logic [31:0]           lo;

    modport master (output start, op, rs_val, rt_val,
                    input  busy, stall, hi, lo);
    modport slave  (input  start, op, rs_val, rt_val,
                    output busy, stall, hi, lo);
endinterface

// File: rtl/md_unit_counter.sv
// md_unit_counter: loadable down-counter that stops at zero.
//   clk, reset  - clock, async active-high reset
//   load_i      - load load_val_i this edge (takes priority over decrement)
//   load_val_i  - latency to load
//   last_o      - count is 1, i.e. the next edge reaches zero
//   zero_o      - count is 0
module md_unit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             last_o,
    output logic             zero_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == WIDTH'(1));
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit beside the ALU. Holds HI/LO, computes the
// result on the accepting edge and commits it after a fixed latency.
//   clk, reset - clock, async active-high reset
//   bus        - md_unit_if.slave: start/op/rs_val/rt_val in,
//                busy/stall/hi/lo out
//
// state   | meaning
// ST_IDLE | no operation pending; start is accepted
// ST_BUSY | result held in pend_q, counter running; start ignored
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e             state_q, state_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    hilo_t              pend_q, pend_d;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_last;
    logic               cnt_zero;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    hilo_t              quo_s;
    hilo_t              quo_u;
    logic               div_by_zero;

    md_unit_counter #(.WIDTH(CNT_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .last_o     (cnt_last),
        .zero_o     (cnt_zero)
    );

    assign prod_s      = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
    assign prod_u      = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    assign quo_s       = div32(bus.rs_val, bus.rt_val, 1'b1);
    assign quo_u       = div32(bus.rs_val, bus.rt_val, 1'b0);
    assign div_by_zero = (bus.rt_val == 32'd0);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pend_d   = pend_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MDUOP_MULT, MDUOP_MULTU: begin
                            pend_d   = (bus.op == MDUOP_MULT) ? hilo_t'(prod_s) : hilo_t'(prod_u);
                            cnt_load = 1'b1;
                            cnt_val  = CNT_W'(MULT_LAT);
                            state_d  = ST_BUSY;
                        end
                        MDUOP_DIV, MDUOP_DIVU: begin
                            // Divide by zero commits the current HI/LO back.
                            if (div_by_zero) begin
                                pend_d = '{hi: hi_q, lo: lo_q};
                            end else begin
                                pend_d = (bus.op == MDUOP_DIV) ? quo_s : quo_u;
                            end
                            cnt_load = 1'b1;
                            cnt_val  = CNT_W'(DIV_LAT);
                            state_d  = ST_BUSY;
                        end
                        MDUOP_MTHI: hi_d = bus.rs_val;
                        MDUOP_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // A zero count while busy cannot happen in normal use;
                // recover to idle rather than hang.
                if (cnt_last) begin
                    hi_d    = pend_q.hi;
                    lo_d    = pend_q.lo;
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.busy  = (state_q == ST_BUSY);
    assign bus.stall = bus.busy | (bus.start & is_long_op(bus.op));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    md_unit_if bus();

    md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.op    = MDUOP_NONE;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    // Issue one op, return at the first negedge with busy low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        present(op, a, b);
        @(negedge clk);
        idle_inputs();
        cyc = 0;
        while (bus.busy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        reset = 1'b0;
        present(MDUOP_MTHI, 32'hAA, 32'h0);
        present(MDUOP_MTLO, 32'hBB, 32'h0);
        @(negedge clk);
        idle_inputs();
        n_cmp++; if ({bus.hi, bus.lo} !== {32'hAA, 32'hBB}) begin n_bad++; $display("FAIL preload_hilo got %h want %h", {bus.hi, bus.lo}, {32'hAA, 32'hBB}); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_bad++; $display("FAIL async_reset_hilo got %h want 0", {bus.hi, bus.lo}); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy got %0b want 0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mt_and_nop();
        present(MDUOP_MTHI, 32'h11, 32'h0);
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mthi_stall got %0b want 0", bus.stall); end
        @(negedge clk);
        idle_inputs();
        n_cmp++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h11, 32'h0}) begin n_bad++; $display("FAIL mthi got busy=%0b hi=%h lo=%h want 0/11/0", bus.busy, bus.hi, bus.lo); end
        present(MDUOP_MTLO, 32'h22, 32'h0);
        @(negedge clk);
        idle_inputs();
        n_cmp++; if ({bus.hi, bus.lo} !== {32'h11, 32'h22}) begin n_bad++; $display("FAIL mtlo got hi=%h lo=%h want 11/22", bus.hi, bus.lo); end
        present(3'd7, 32'h55, 32'h66);
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL undef_op_stall got %0b want 0", bus.stall); end
        present(MDUOP_NONE, 32'h77, 32'h0);
        @(negedge clk);
        idle_inputs();
        n_cmp++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h11, 32'h22}) begin n_bad++; $display("FAIL nop got busy=%0b hi=%h lo=%h want 0/11/22", bus.busy, bus.hi, bus.lo); end
    endtask

    task automatic test_div_zero();
        int cyc;
        run_op(MDUOP_DIVU, 32'h1234, 32'h0, cyc);
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL divzero_busy got %0d want 10", cyc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'h11, 32'h22}) begin n_bad++; $display("FAIL divzero_hilo got %h want %h", {bus.hi, bus.lo}, {32'h11, 32'h22}); end
    endtask

    task automatic test_mult();
        int cyc;
        run_op(MDUOP_MULT, 32'hFFFFFFFE, 32'h3, cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL mult_busy got %0d want 5", cyc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'hFFFFFFFF, 32'hFFFFFFFA}) begin n_bad++; $display("FAIL mult_hilo got %h want FFFFFFFFFFFFFFFA", {bus.hi, bus.lo}); end
        run_op(MDUOP_MULTU, 32'hFFFFFFFE, 32'h3, cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL multu_busy got %0d want 5", cyc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'h2, 32'hFFFFFFFA}) begin n_bad++; $display("FAIL multu_hilo got %h want 00000002FFFFFFFA", {bus.hi, bus.lo}); end
    endtask

    task automatic test_div();
        int cyc;
        run_op(MDUOP_DIV, 32'hFFFFFFF9, 32'h2, cyc);
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL div_busy got %0d want 10", cyc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_bad++; $display("FAIL div_neg_hilo got %h want FFFFFFFFFFFFFFFD", {bus.hi, bus.lo}); end
        run_op(MDUOP_DIVU, 32'h7, 32'h2, cyc);
        n_cmp++; if ({bus.hi, bus.lo} !== {32'h1, 32'h3}) begin n_bad++; $display("FAIL divu_hilo got %h want 0000000100000003", {bus.hi, bus.lo}); end
        run_op(MDUOP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_cmp++; if ({bus.hi, bus.lo} !== {32'h0, 32'h80000000}) begin n_bad++; $display("FAIL div_ovf_hilo got %h want 0000000080000000", {bus.hi, bus.lo}); end
        run_op(MDUOP_DIV, 32'h7, 32'hFFFFFFFE, cyc);
        n_cmp++; if ({bus.hi, bus.lo} !== {32'h1, 32'hFFFFFFFD}) begin n_bad++; $display("FAIL div_negdiv_hilo got %h want 00000001FFFFFFFD", {bus.hi, bus.lo}); end
    endtask

    task automatic test_start_while_busy();
        int n;
        int stall_low;
        n = 0;
        stall_low = 0;
        present(MDUOP_DIV, 32'd100, 32'd7);
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL div_start_stall got %0b want 1", bus.stall); end
        @(negedge clk);
        idle_inputs();
        while (bus.busy && n < 50) begin
            n++;
            if (bus.stall !== 1'b1) stall_low++;
            if (n == 3 || n == 10) begin
                bus.start = 1'b1; bus.op = MDUOP_MULT; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
            end else if (n == 5) begin
                bus.start = 1'b1; bus.op = MDUOP_MTLO; bus.rs_val = 32'hDEAD;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        idle_inputs();
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL busy_window got %0d want 10", n); end
        n_cmp++; if (stall_low !== 0) begin n_bad++; $display("FAIL stall_during_busy got %0d low cycles want 0", stall_low); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL ignored_start_hilo got %h want %h", {bus.hi, bus.lo}, {32'd2, 32'd14}); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL commit_edge_start got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] pat;
        pat = '0;
        present(MDUOP_MULT, 32'd3, 32'd3);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[i] = bus.busy;
        end
        idle_inputs();
        n_cmp++; if (pat !== 12'h7DF) begin n_bad++; $display("FAIL b2b_busy_pattern got %b want %b", pat, 12'h7DF); end
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'd0, 32'd9}) begin n_bad++; $display("FAIL b2b_result got busy=%0b hi=%h lo=%h want 0/0/9", bus.busy, bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        present(MDUOP_MULT, 32'd6, 32'd7);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({bus.busy, bus.hi, bus.lo} !== 65'h0) begin n_bad++; $display("FAIL reset_mid got busy=%0b hi=%h lo=%h want all 0", bus.busy, bus.hi, bus.lo); end
        @(negedge clk);
        reset = 1'b0;
        run_op(MDUOP_MULT, 32'd4, 32'd5, cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL post_reset_busy got %0d want 5", cyc); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd0, 32'd20}) begin n_bad++; $display("FAIL post_reset_mult got %h want %h", {bus.hi, bus.lo}, {32'd0, 32'd20}); end
    endtask

    initial begin
        test_reset();
        test_mt_and_nop();
        test_div_zero();
        test_mult();
        test_div();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
